// File: rtl/qspim_sfifo.sv
// qspim_sfifo: synchronous FIFO for the QSPI master TX/RX datapath.
// Arbitrary depth, FWFT or registered read, programmable almost-full/empty.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   flush                   sync clear of pointers and level
//   wr_en, wr_data          write request and data
//   full, afull             level == DP, level >= afull_thr
//   rd_en                   read request
//   rd_data, rd_valid       read data and valid qualifier
//   empty, aempty           level == 0, level <= aempty_thr
//   afull_thr, aempty_thr   quasi-static thresholds
//   level                   occupancy 0..DP
//   ovf, udf, err_clr       sticky error flags and their clear
module qspim_sfifo #(
  parameter int W       = 8,
  parameter int DP      = 4,
  parameter int RD_MODE = 0,
  parameter int AW      = $clog2(DP)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  output logic          full,
  output logic          afull,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          aempty,
  input  logic [AW:0]   afull_thr,
  input  logic [AW:0]   aempty_thr,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf,
  input  logic          err_clr
);

  localparam logic [AW:0]   DPL  = (AW+1)'(DP);
  localparam logic [AW-1:0] LAST = AW'(DP-1);

  logic [W-1:0]  mem [DP];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   lvl_q;
  logic          wr_acc;
  logic          rd_acc;
  logic          ovf_set;
  logic          udf_set;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  assign level  = lvl_q;
  assign full   = (lvl_q == DPL);
  assign empty  = (lvl_q == '0);
  assign afull  = (lvl_q >= afull_thr);
  assign aempty = (lvl_q <= aempty_thr);

  assign wr_acc  = wr_en & ~full & ~flush;
  assign rd_acc  = rd_en & ~empty & ~flush;
  assign ovf_set = wr_en & full & ~flush;
  assign udf_set = rd_en & empty & ~flush;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= nxt(wr_ptr);
      if (rd_acc) rd_ptr <= nxt(rd_ptr);
      unique case ({wr_acc, rd_acc})
        2'b10:   lvl_q <= lvl_q + (AW+1)'(1);
        2'b01:   lvl_q <= lvl_q - (AW+1)'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  // A new error event beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~err_clr);
      udf <= udf_set | (udf & ~err_clr);
    end
  end

  if (RD_MODE == 1) begin : g_reg
    logic [W-1:0] rd_q;
    logic         vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_q  <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= rd_acc;
        if (rd_acc) rd_q <= mem[rd_ptr];
      end
    end

    assign rd_data  = rd_q;
    assign rd_valid = vld_q;
  end else begin : g_fwft
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = ~empty;
  end

endmodule

// File: tb/tb_qspim_sfifo.sv
// tb_qspim_sfifo: directed self-checking bench for qspim_sfifo.
// Instance u0 is FWFT (DP=5), instance u1 is registered read (DP=5).
module tb_qspim_sfifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       flush0 = 0, wr_en0 = 0, rd_en0 = 0, err_clr0 = 0;
  logic [7:0] wr_data0 = '0;
  logic [3:0] afull_thr0 = '0, aempty_thr0 = 4'd1;
  logic       full0, afull0, empty0, aempty0, rd_valid0, ovf0, udf0;
  logic [7:0] rd_data0;
  logic [3:0] level0;

  logic       flush1 = 0, wr_en1 = 0, rd_en1 = 0, err_clr1 = 0;
  logic [7:0] wr_data1 = '0;
  logic [3:0] afull_thr1 = 4'd4, aempty_thr1 = 4'd1;
  logic       full1, afull1, empty1, aempty1, rd_valid1, ovf1, udf1;
  logic [7:0] rd_data1;
  logic [3:0] level1;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  qspim_sfifo #(.W(8), .DP(5), .RD_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .flush(flush0),
    .wr_en(wr_en0), .wr_data(wr_data0),
    .full(full0), .afull(afull0),
    .rd_en(rd_en0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .empty(empty0), .aempty(aempty0),
    .afull_thr(afull_thr0), .aempty_thr(aempty_thr0),
    .level(level0), .ovf(ovf0), .udf(udf0), .err_clr(err_clr0)
  );

  qspim_sfifo #(.W(8), .DP(5), .RD_MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .flush(flush1),
    .wr_en(wr_en1), .wr_data(wr_data1),
    .full(full1), .afull(afull1),
    .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .empty(empty1), .aempty(aempty1),
    .afull_thr(afull_thr1), .aempty_thr(aempty_thr1),
    .level(level1), .ovf(ovf1), .udf(udf1), .err_clr(err_clr1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [7:0] d);
    wr_en0 = 1'b1;
    wr_data0 = d;
    tick();
    wr_en0 = 1'b0;
    #1;
  endtask

  task automatic rd0(input logic [7:0] exp);
    chk("fwft_data", rd_data0, exp);
    rd_en0 = 1'b1;
    tick();
    rd_en0 = 1'b0;
    #1;
  endtask

  task automatic wr1(input logic [7:0] d);
    wr_en1 = 1'b1;
    wr_data1 = d;
    tick();
    wr_en1 = 1'b0;
    #1;
  endtask

  initial begin
    #2;
    chk("rst_level", level0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_aempty", aempty0, 1);
    chk("rst_afull_thr0", afull0, 1);
    chk("rst_ovf", ovf0, 0);
    chk("rst_udf", udf0, 0);
    chk("rst_fwft_valid", rd_valid0, 0);
    chk("rst_reg_valid", rd_valid1, 0);
    chk("rst_reg_data", rd_data1, 0);
    afull_thr0 = 4'd3;
    #1;
    chk("rst_afull_thr3", afull0, 0);
    #9;
    reset_n = 1'b1;
    tick();
    chk("idle_empty", empty0, 1);

    // Fill with threshold tracking (afull_thr=3, aempty_thr=1)
    wr0(8'h11);
    chk("l1_level", level0, 1);
    chk("l1_empty", empty0, 0);
    chk("l1_aempty", aempty0, 1);
    chk("l1_afull", afull0, 0);
    wr0(8'h22);
    chk("l2_aempty", aempty0, 0);
    chk("l2_afull", afull0, 0);
    afull_thr0 = 4'd2;
    #1;
    chk("thr2_afull", afull0, 1);
    afull_thr0 = 4'd3;
    #1;
    chk("thr3_afull", afull0, 0);
    wr0(8'h33);
    chk("l3_afull", afull0, 1);
    wr0(8'h44);
    wr0(8'h55);
    chk("l5_full", full0, 1);
    chk("l5_level", level0, 5);
    afull_thr0 = 4'd7;
    aempty_thr0 = 4'd6;
    #1;
    chk("big_afull", afull0, 0);
    chk("big_aempty", aempty0, 1);
    afull_thr0 = 4'd3;
    aempty_thr0 = 4'd1;
    wr0(8'h66);
    chk("ovf_set", ovf0, 1);
    chk("ovf_level", level0, 5);
    chk("ovf_head", rd_data0, 8'h11);
    rd0(8'h11);
    rd0(8'h22);
    rd0(8'h33);
    rd0(8'h44);
    rd0(8'h55);
    chk("drain_empty", empty0, 1);
    chk("drain_valid", rd_valid0, 0);
    chk("ovf_sticky", ovf0, 1);
    err_clr0 = 1'b1;
    tick();
    err_clr0 = 1'b0;
    chk("ovf_clr", ovf0, 0);

    // Wrap: hold two entries across 13 write/read pairs
    wr0(8'h80);
    wr0(8'h81);
    for (int i = 0; i < 13; i++) begin
      chk("wrap_data", rd_data0, 8'h80 + 8'(i));
      wr_en0 = 1'b1;
      rd_en0 = 1'b1;
      wr_data0 = 8'h82 + 8'(i);
      tick();
      chk("wrap_level", level0, 2);
    end
    wr_en0 = 1'b0;
    rd_en0 = 1'b0;
    #1;
    rd0(8'h8D);
    rd0(8'h8E);
    chk("wrap_empty", empty0, 1);
    chk("wrap_no_err", {ovf0, udf0}, 2'b00);

    // Flush beats concurrent write and read
    wr0(8'h01);
    wr0(8'h02);
    wr0(8'h03);
    chk("pre_flush_level", level0, 3);
    flush0 = 1'b1;
    wr_en0 = 1'b1;
    rd_en0 = 1'b1;
    tick();
    flush0 = 1'b0;
    wr_en0 = 1'b0;
    rd_en0 = 1'b0;
    #1;
    chk("flush_level", level0, 0);
    chk("flush_empty", empty0, 1);
    chk("flush_err", {ovf0, udf0}, 2'b00);
    rd_en0 = 1'b1;
    tick();
    rd_en0 = 1'b0;
    chk("udf_set", udf0, 1);
    chk("udf_level", level0, 0);
    rd_en0 = 1'b1;
    err_clr0 = 1'b1;
    tick();
    rd_en0 = 1'b0;
    chk("udf_set_wins", udf0, 1);
    tick();
    err_clr0 = 1'b0;
    chk("udf_clr", udf0, 0);

    // Registered read mode
    wr1(8'hA5);
    wr1(8'h5A);
    chk("reg_idle_valid", rd_valid1, 0);
    rd_en1 = 1'b1;
    tick();
    chk("reg_v1", rd_valid1, 1);
    chk("reg_d1", rd_data1, 8'hA5);
    tick();
    rd_en1 = 1'b0;
    chk("reg_v2", rd_valid1, 1);
    chk("reg_d2", rd_data1, 8'h5A);
    tick();
    chk("reg_v3", rd_valid1, 0);
    chk("reg_hold", rd_data1, 8'h5A);
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    chk("reg_udf_valid", rd_valid1, 0);
    chk("reg_udf", udf1, 1);

    // Async reset mid-burst
    wr0(8'h31);
    wr0(8'h32);
    wr0(8'h33);
    wr0(8'h34);
    chk("pre_rst_level", level0, 4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_level", level0, 0);
    chk("arst_empty", empty0, 1);
    chk("arst_aempty", aempty0, 1);
    chk("arst_reg_data", rd_data1, 0);
    chk("arst_udf", udf1, 0);
    #4;
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
